instruction_queue: RTL and testbench

- Parametrised successor to the single-entry instruction register: a clocked FIFO of fetched instruction words sitting between instruction memory and the decode/control FSM.
- Lets the fetch side run ahead of decode and presents the head entry already split into the standard instruction fields.
- Supports flushing on taken branch/jump, and reports occupancy and overflow.

---
 rtl/instruction_queue_if.sv | 34 +++
 rtl/instruction_queue.sv | 83 ++++++++
 tb/tb_instruction_queue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - fetch/decode handshake bundle for the instruction queue
interface instruction_queue_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 3
);
  logic [INSTR_W-1:0] D_MemData;
  logic               C_IRWrite;
  logic               C_IRAdvance;
  logic               C_Flush;
  logic               Q_Full;
  logic               Q_Valid;
  logic [CNT_W-1:0]   Q_Count;
  logic               Q_Overflow;
  logic [INSTR_W-1:0] HEAD_WORD;
  logic [3:0]         OPCODE;
  logic [3:0]         FUNCFIELD;
  logic [3:0]         A_ReadReg1RT;
  logic [3:0]         A_ReadReg2RT;
  logic [1:0]         A_Offset;
  logic [1:0]         A_RegSWLW;
  logic [3:0]         A_WriteRegRT_BT;

  modport master (
    output D_MemData, C_IRWrite, C_IRAdvance, C_Flush,
    input  Q_Full, Q_Valid, Q_Count, Q_Overflow, HEAD_WORD, OPCODE, FUNCFIELD,
           A_ReadReg1RT, A_ReadReg2RT, A_Offset, A_RegSWLW, A_WriteRegRT_BT
  );

  modport slave (
    input  D_MemData, C_IRWrite, C_IRAdvance, C_Flush,
    output Q_Full, Q_Valid, Q_Count, Q_Overflow, HEAD_WORD, OPCODE, FUNCFIELD,
           A_ReadReg1RT, A_ReadReg2RT, A_Offset, A_RegSWLW, A_WriteRegRT_BT
  );
endinterface

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - instruction FIFO with field-split head; IQ_BYPASS_EN enables empty-queue bypass
module instruction_queue #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               rst,
  instruction_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  logic               full, head_valid, pop_ok, push_ok;
  logic [INSTR_W-1:0] head_word;

  assign full = (count == CNT_W'(DEPTH));

  always_comb begin
    head_valid = (count != '0);
    head_word  = mem[rd_ptr];
`ifdef IQ_BYPASS_EN
    // Empty queue: forward the incoming word so decode can start this cycle.
    if (count == '0 && q.C_IRWrite && !q.C_Flush) begin
      head_valid = 1'b1;
      head_word  = q.D_MemData;
    end
`endif
    if (!head_valid)
      head_word = '0;
  end

  assign pop_ok  = q.C_IRAdvance & head_valid;
  assign push_ok = q.C_IRWrite & (~full | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (q.C_Flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)
        count <= count + CNT_W'(1);
      else if (pop_ok && !push_ok)
        count <= count - CNT_W'(1);
      if (q.C_IRWrite && !push_ok)
        overflow <= 1'b1;
    end
  end

  // A bypassed push+pop writes a slot that both pointers step past, so it never becomes visible.
  always_ff @(posedge clk) begin
    if (push_ok && !q.C_Flush)
      mem[wr_ptr] <= q.D_MemData;
  end

  assign q.Q_Full          = full;
  assign q.Q_Valid         = head_valid;
  assign q.Q_Count         = count;
  assign q.Q_Overflow      = overflow;
  assign q.HEAD_WORD       = head_word;
  assign q.OPCODE          = head_word[15:12];
  assign q.FUNCFIELD       = head_word[3:0];
  assign q.A_ReadReg1RT    = head_word[7:4];
  assign q.A_ReadReg2RT    = head_word[3:0];
  assign q.A_Offset        = head_word[9:8];
  assign q.A_RegSWLW       = head_word[11:10];
  assign q.A_WriteRegRT_BT = head_word[11:8];
endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed and random checks of instruction_queue against a queue model
module tb_instruction_queue;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_queue_if #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  instruction_queue #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] model_q [$];
  logic        model_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] h;
    h = (model_q.size() > 0) ? model_q[0] : 16'h0;
    chk({tag, ".count"}, 32'(bus.Q_Count), 32'(model_q.size()));
    chk({tag, ".valid"}, 32'(bus.Q_Valid), 32'(model_q.size() != 0));
    chk({tag, ".full"},  32'(bus.Q_Full),  32'(model_q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(bus.Q_Overflow), 32'(model_ovf));
    chk({tag, ".head"},  32'(bus.HEAD_WORD), 32'(h));
    chk({tag, ".fields"},
        {bus.OPCODE, bus.FUNCFIELD, bus.A_ReadReg1RT, bus.A_ReadReg2RT,
         bus.A_Offset, bus.A_RegSWLW, bus.A_WriteRegRT_BT, 4'h0},
        {h[15:12], h[3:0], h[7:4], h[3:0], h[9:8], h[11:10], h[11:8], 4'h0});
  endtask

  task automatic set_in(input logic w, input logic [15:0] d, input logic adv, input logic fl);
    bus.C_IRWrite   = w;
    bus.D_MemData   = d;
    bus.C_IRAdvance = adv;
    bus.C_Flush     = fl;
  endtask

  // Called at a negedge; applies one clock of stimulus, updates the model, then checks with idle inputs.
  task automatic step(input string tag, input logic w, input logic [15:0] d,
                      input logic adv, input logic fl);
    bit has_head, pop, push;
    set_in(w, d, adv, fl);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      has_head = model_q.size() > 0;
`ifdef IQ_BYPASS_EN
      has_head = has_head || w;
`endif
      pop  = adv && has_head;
      push = w && (model_q.size() < DEPTH || pop);
      if (push) model_q.push_back(d);
      if (pop)  void'(model_q.pop_front());
      if (w && !push) model_ovf = 1'b1;
    end
    @(negedge clk);
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    check_all(tag);
  endtask

  initial begin
    set_in(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step("push1", 1, 16'h8B48, 0, 0);
    chk("push1.opcode", 32'(bus.OPCODE), 32'h8);
    chk("push1.wrbt",   32'(bus.A_WriteRegRT_BT), 32'hB);
    chk("push1.swlw_off", {bus.A_RegSWLW, bus.A_Offset}, 4'b1011);

    step("fill2", 1, 16'h9BC9, 0, 0);
    step("fill3", 1, 16'h2BC9, 0, 0);
    step("fill4", 1, 16'h3B78, 0, 0);
    chk("fill4.full", 32'(bus.Q_Full), 32'h1);
    step("drop5", 1, 16'hDEAD, 0, 0);
    chk("drop5.ovf", 32'(bus.Q_Overflow), 32'h1);
    for (int i = 0; i < 4; i++) step("drain", 0, 16'h0, 1, 0);
    chk("drain.valid", 32'(bus.Q_Valid), 32'h0);

    step("flush_clr", 0, 16'h0, 0, 1);
    step("refill1", 1, 16'h8B48, 0, 0);
    step("refill2", 1, 16'h9BC9, 0, 0);
    step("refill3", 1, 16'h2BC9, 0, 0);
    step("refill4", 1, 16'h3B78, 0, 0);
    step("pushpop_full", 1, 16'h1BC9, 1, 0);
    chk("pushpop.head", 32'(bus.HEAD_WORD), 32'h9BC9);
    for (int i = 0; i < 4; i++) step("wrap_drain", 0, 16'h0, 1, 0);

    step("c3a", 1, 16'h1111, 0, 0);
    step("c3b", 1, 16'h2222, 0, 0);
    step("c3c", 1, 16'h3333, 0, 0);
    step("flush_all", 1, 16'h4444, 1, 1);
    chk("flush_all.count", 32'(bus.Q_Count), 32'h0);

    step("r1", 1, 16'h5A5A, 0, 0);
    step("r2", 1, 16'hA5A5, 0, 0);
    #2;
    rst = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    check_all("async_rst");
    rst = 1'b0;
    @(negedge clk);
    step("post_rst", 1, 16'h2BC9, 0, 0);
    chk("post_rst.opcode", 32'(bus.OPCODE), 32'h2);
    chk("post_rst.swlw",   32'(bus.A_RegSWLW), 32'h2);

    step("pop_empty0", 0, 16'h0, 1, 0);
    step("pop_empty1", 0, 16'h0, 1, 0);

`ifdef IQ_BYPASS_EN
    set_in(1'b1, 16'h8B48, 1'b1, 1'b0);
    #1;
    chk("bypass.opcode", 32'(bus.OPCODE), 32'h8);
    chk("bypass.valid",  32'(bus.Q_Valid), 32'h1);
    step("bypass", 1, 16'h8B48, 1, 0);
    chk("bypass.count",  32'(bus.Q_Count), 32'h0);
`endif

    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 9) < 6), 16'($urandom), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 19) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
